// File: rtl/dcache_evict_buffer_pkg.sv
// Shared data-cache defines: geometry, AXI ids/encodings and the write-back FSM states.
// Imported by the eviction buffer and its bench.
package dcache_evict_buffer_pkg;

   localparam int PADDR_SIZE  = 32;
   localparam int DATA_BYTE   = 8;     // AXI data bus width in bytes
   localparam int DCACHE_LINE = 32;    // line size in bytes
   localparam int DCACHE_BANK = 4;
   localparam int DCACHE_BITS = 64;
   localparam int EVB_DEPTH   = 4;

   localparam int                  AXI_ID_W  = 4;
   localparam logic [AXI_ID_W-1:0] DCACHE_ID = 4'd1;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [2:0] AXI_SIZE_DATA  = 3'($clog2(DATA_BYTE));

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_AW,
      WB_W,
      WB_B
   } wb_state_e;

endpackage

// File: rtl/dcache_evict_buffer.sv
// Dirty-victim buffer: holds evicted lines until the replacing refill is released,
// then writes them back over AXI strictly in allocation order.
module dcache_evict_buffer
   import dcache_evict_buffer_pkg::*;
#(
   parameter int DEPTH = EVB_DEPTH,
   parameter int BEATS = DCACHE_LINE / DATA_BYTE
)(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enq_valid,
   output logic                               enq_ready,
   input  logic [PADDR_SIZE-1:0]              enq_addr,
   input  logic [DCACHE_BANK*DCACHE_BITS-1:0] enq_data,
   output logic [$clog2(DEPTH)-1:0]           enq_idx,
   input  logic                               release_valid,
   input  logic [$clog2(DEPTH)-1:0]           release_idx,
   input  logic [PADDR_SIZE-1:0]              probe_addr,
   output logic                               probe_hit,
   output logic                               aw_valid,
   input  logic                               aw_ready,
   output logic [AXI_ID_W-1:0]                aw_id,
   output logic [PADDR_SIZE-1:0]              aw_addr,
   output logic [7:0]                         aw_len,
   output logic [2:0]                         aw_size,
   output logic [1:0]                         aw_burst,
   output logic                               aw_lock,
   output logic [3:0]                         aw_cache,
   output logic [2:0]                         aw_prot,
   output logic [3:0]                         aw_qos,
   output logic [3:0]                         aw_region,
   output logic                               w_valid,
   input  logic                               w_ready,
   output logic [DATA_BYTE*8-1:0]             w_data,
   output logic [DATA_BYTE-1:0]               w_strb,
   output logic                               w_last,
   input  logic                               b_valid,
   output logic                               b_ready,
   input  logic [AXI_ID_W-1:0]                b_id,
   input  logic [1:0]                         b_resp
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int BEAT_W = DATA_BYTE * 8;
   localparam int LINE_W = DCACHE_BANK * DCACHE_BITS;
   localparam int OFF_W  = $clog2(DCACHE_LINE);
   localparam int TAG_W  = PADDR_SIZE - OFF_W;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef struct packed {
      logic [TAG_W-1:0]  line;
      logic [LINE_W-1:0] data;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] released;
   logic [IDX_W-1:0] head;
   logic [IDX_W-1:0] tail;
   logic [CNT_W-1:0] beat_cnt;
   wb_state_e        state;

   logic             enq_fire;
   logic             release_ok;
   logic             head_go;
   logic [DEPTH-1:0] hit_vec;
   logic [BEAT_W-1:0] beat [BEATS];
   logic             unused_ok;

   assign enq_ready  = ~valid[tail];
   assign enq_idx    = tail;
   assign enq_fire   = enq_valid & enq_ready;
   assign release_ok = release_valid & valid[release_idx];
   // A release aimed at the head is honoured the same cycle so AW can rise one cycle later.
   assign head_go    = valid[head] & (released[head] | (release_valid & (release_idx == head)));

   // Payload storage is never reset; valid qualifies every use.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         mem[tail] <= '{line: enq_addr[PADDR_SIZE-1:OFF_W], data: enq_data};
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_probe
      assign hit_vec[gi] = valid[gi] & (mem[gi].line == probe_addr[PADDR_SIZE-1:OFF_W]);
   end
   assign probe_hit = |hit_vec;

   for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beat[gi] = mem[head].data[gi*BEAT_W +: BEAT_W];
   end

   assign aw_id     = DCACHE_ID;
   assign aw_addr   = {mem[head].line, OFF_W'(0)};
   assign aw_len    = 8'(BEATS - 1);
   assign aw_size   = AXI_SIZE_DATA;
   assign aw_burst  = AXI_BURST_INCR;
   assign aw_lock   = 1'b0;
   assign aw_cache  = 4'd0;
   assign aw_prot   = 3'd0;
   assign aw_qos    = 4'd0;
   assign aw_region = 4'd0;
   assign w_data    = beat[beat_cnt];
   assign w_strb    = '1;
   assign w_last    = w_valid & (beat_cnt == CNT_W'(BEATS - 1));

   // Any b_resp completes the entry; errors are not retried.
   assign unused_ok = ^{b_id, b_resp, enq_addr[OFF_W-1:0], probe_addr[OFF_W-1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid    <= '0;
         released <= '0;
         head     <= '0;
         tail     <= '0;
         beat_cnt <= '0;
         state    <= WB_IDLE;
         aw_valid <= 1'b0;
         w_valid  <= 1'b0;
         b_ready  <= 1'b0;
      end else begin
         if (release_ok) begin
            released[release_idx] <= 1'b1;
         end
         if (enq_fire) begin
            valid[tail]    <= 1'b1;
            released[tail] <= 1'b0;
            tail           <= tail + 1'b1;
         end
         case (state)
            WB_IDLE: begin
               if (head_go) begin
                  state    <= WB_AW;
                  aw_valid <= 1'b1;
               end
            end
            WB_AW: begin
               if (aw_ready) begin
                  state    <= WB_W;
                  aw_valid <= 1'b0;
                  w_valid  <= 1'b1;
               end
            end
            WB_W: begin
               if (w_ready) begin
                  if (w_last) begin
                     state    <= WB_B;
                     w_valid  <= 1'b0;
                     b_ready  <= 1'b1;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            WB_B: begin
               if (b_valid) begin
                  valid[head]    <= 1'b0;
                  released[head] <= 1'b0;
                  head           <= head + 1'b1;
                  beat_cnt       <= '0;
                  b_ready        <= 1'b0;
                  state          <= WB_IDLE;
               end
            end
            default: state <= WB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_evict_buffer.sv
// Randomized scoreboard bench for dcache_evict_buffer: a slot-level model predicts
// allocation, probe results and the FIFO-ordered AXI write-back stream.
module tb_dcache_evict_buffer;
   import dcache_evict_buffer_pkg::*;

   localparam int DEPTH  = EVB_DEPTH;
   localparam int BEATS  = DCACHE_LINE / DATA_BYTE;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int BEAT_W = DATA_BYTE * 8;
   localparam int LINE_W = DCACHE_BANK * DCACHE_BITS;
   localparam int OFF_W  = $clog2(DCACHE_LINE);

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    enq_valid = 1'b0;
   logic                    enq_ready;
   logic [PADDR_SIZE-1:0]   enq_addr = '0;
   logic [LINE_W-1:0]       enq_data = '0;
   logic [IDX_W-1:0]        enq_idx;
   logic                    release_valid = 1'b0;
   logic [IDX_W-1:0]        release_idx = '0;
   logic [PADDR_SIZE-1:0]   probe_addr = '0;
   logic                    probe_hit;
   logic                    aw_valid;
   logic                    aw_ready = 1'b0;
   logic [AXI_ID_W-1:0]     aw_id;
   logic [PADDR_SIZE-1:0]   aw_addr;
   logic [7:0]              aw_len;
   logic [2:0]              aw_size;
   logic [1:0]              aw_burst;
   logic                    aw_lock;
   logic [3:0]              aw_cache;
   logic [2:0]              aw_prot;
   logic [3:0]              aw_qos;
   logic [3:0]              aw_region;
   logic                    w_valid;
   logic                    w_ready = 1'b0;
   logic [BEAT_W-1:0]       w_data;
   logic [DATA_BYTE-1:0]    w_strb;
   logic                    w_last;
   logic                    b_valid = 1'b0;
   logic                    b_ready;
   logic [AXI_ID_W-1:0]     b_id = DCACHE_ID;
   logic [1:0]              b_resp = AXI_RESP_OKAY;

   dcache_evict_buffer dut (
      .clk(clk), .rst(rst),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
      .enq_data(enq_data), .enq_idx(enq_idx),
      .release_valid(release_valid), .release_idx(release_idx),
      .probe_addr(probe_addr), .probe_hit(probe_hit),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
      .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_lock(aw_lock),
      .aw_cache(aw_cache), .aw_prot(aw_prot), .aw_qos(aw_qos), .aw_region(aw_region),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
      .w_last(w_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [PADDR_SIZE-1:0] addr;
      logic [LINE_W-1:0]     data;
      int                    idx;
   } wr_t;

   logic                  m_valid [DEPTH];
   logic                  m_rel   [DEPTH];
   logic [PADDR_SIZE-1:0] m_addr  [DEPTH];
   int                    m_tail;
   wr_t                   exp_q [$];
   wr_t                   cur;
   bit                    aw_done;
   int                    bcount;
   bit                    bpend;
   bit                    prev_aw_stall;
   bit                    prev_w_stall;
   logic [PADDR_SIZE-1:0] prev_awaddr;
   logic [BEAT_W-1:0]     prev_wdata;

   int aw_pct = 100;
   int w_pct  = 100;
   int b_pct  = 100;
   bit w_toggle = 1'b0;

   function automatic logic model_probe(input logic [PADDR_SIZE-1:0] a);
      logic hit = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (m_valid[i] && m_addr[i][PADDR_SIZE-1:OFF_W] == a[PADDR_SIZE-1:OFF_W]) hit = 1'b1;
      return hit;
   endfunction

   function automatic bit model_busy();
      bit busy = 1'b0;
      for (int i = 0; i < DEPTH; i++) if (m_valid[i]) busy = 1'b1;
      return busy;
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] r;
      for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   // Monitor: compares on the falling edge, then advances the model to the next rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_rel[i]   = 1'b0;
         end
         m_tail = 0;
         exp_q.delete();
         aw_done = 1'b0;
         bcount = 0;
         bpend = 1'b0;
         prev_aw_stall = 1'b0;
         prev_w_stall = 1'b0;
      end else begin
         check("enq_ready", enq_ready, !m_valid[m_tail]);
         check("enq_idx", enq_idx, m_tail);
         check("probe_hit", probe_hit, model_probe(probe_addr));
         if (prev_aw_stall) begin
            check("aw_valid_hold", aw_valid, 1);
            check("aw_addr_hold", aw_addr, prev_awaddr);
         end
         if (prev_w_stall) begin
            check("w_valid_hold", w_valid, 1);
            check("w_data_hold", w_data, prev_wdata);
         end
         if (w_valid) check("w_after_aw", aw_done, 1);
         if (aw_valid) begin
            if (exp_q.size() == 0) check("aw_unexpected", aw_valid, 0);
            else check("aw_head_released", m_rel[exp_q[0].idx], 1);
         end
         if (aw_valid && aw_ready && exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("aw_addr", aw_addr, {cur.addr[PADDR_SIZE-1:OFF_W], OFF_W'(0)});
            check("aw_len", aw_len, BEATS - 1);
            check("aw_size", aw_size, $clog2(DATA_BYTE));
            check("aw_burst", aw_burst, 2'b01);
            check("aw_id", aw_id, DCACHE_ID);
            check("aw_other", {aw_lock, aw_cache, aw_prot, aw_qos, aw_region}, 0);
            aw_done = 1'b1;
            bcount = 0;
         end
         if (w_valid && w_ready) begin
            check("w_data", w_data, cur.data[bcount*BEAT_W +: BEAT_W]);
            check("w_last", w_last, bcount == BEATS - 1);
            check("w_strb", w_strb, {DATA_BYTE{1'b1}});
            if (bcount == BEATS - 1) bpend = 1'b1;
            bcount++;
         end
         if (release_valid && m_valid[release_idx]) m_rel[release_idx] = 1'b1;
         if (enq_valid && !m_valid[m_tail]) begin
            m_valid[m_tail] = 1'b1;
            m_rel[m_tail]   = 1'b0;
            m_addr[m_tail]  = enq_addr;
            exp_q.push_back('{addr: enq_addr, data: enq_data, idx: m_tail});
            m_tail = (m_tail + 1) % DEPTH;
         end
         if (b_valid && b_ready) begin
            check("b_beat_total", bcount, BEATS);
            m_valid[cur.idx] = 1'b0;
            m_rel[cur.idx]   = 1'b0;
            aw_done = 1'b0;
            bpend = 1'b0;
         end
         prev_aw_stall = aw_valid && !aw_ready;
         prev_awaddr   = aw_addr;
         prev_w_stall  = w_valid && !w_ready;
         prev_wdata    = w_data;
      end
   end

   // AXI slave responder
   always @(posedge clk) begin
      #1;
      aw_ready = ($urandom_range(0, 99) < aw_pct);
      if (w_toggle) w_ready = !w_ready;
      else w_ready = ($urandom_range(0, 99) < w_pct);
      b_valid = bpend && (b_valid || ($urandom_range(0, 99) < b_pct));
      b_resp  = 2'($urandom_range(0, 3));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_enq(input logic [PADDR_SIZE-1:0] a, input logic [LINE_W-1:0] d);
      enq_valid = 1'b1;
      enq_addr  = a;
      enq_data  = d;
      tick();
      enq_valid = 1'b0;
   endtask

   task automatic do_rel(input int idx);
      release_valid = 1'b1;
      release_idx   = IDX_W'(idx);
      tick();
      release_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic wait_empty(input string nm);
      int n = 0;
      while (model_busy() && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (model_busy()) begin
         errors++;
         $display("FAIL %s: actual=entries still held required=drained within 300 cycles", nm);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   logic [PADDR_SIZE-1:0] fill_addr [DEPTH];

   initial begin
      int n;
      // reset values
      tick();
      @(negedge clk);
      check("rst_aw_valid", aw_valid, 0);
      check("rst_w_valid", w_valid, 0);
      check("rst_b_ready", b_ready, 0);
      check("rst_enq_ready", enq_ready, 1);
      check("rst_probe_hit", probe_hit, 0);
      tick();
      rst = 1'b1;
      tick();

      // single victim with latency measurements
      probe_addr = 32'h8000_1000;
      do_enq(32'h8000_1000, rand_line());
      do_rel(0);
      check("rel_to_aw_valid", aw_valid, 1);
      check("single_aw_addr", aw_addr, 32'h8000_1000);
      n = 1;
      while (probe_hit && n < 50) begin
         tick();
         n++;
      end
      check("rel_to_free_cycles", n, BEATS + 3);
      check("single_enq_ready", enq_ready, 1);
      wait_empty("single");

      // fill, overflow, probes, out-of-order release
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         fill_addr[i] = 32'h8000_2000 + 32'(i * 64);
         check("fill_idx", enq_idx, i);
         do_enq(fill_addr[i], rand_line());
      end
      check("full_enq_ready", enq_ready, 0);
      do_enq(32'h8000_3000, rand_line());
      check("full_ignored_tail", enq_idx, 0);
      for (int i = 0; i < DEPTH; i++) begin
         probe_addr = fill_addr[i] + 32'd8;
         @(negedge clk);
         check("fill_probe", probe_hit, 1);
         tick();
      end
      probe_addr = 32'h8000_3000;
      @(negedge clk);
      check("overflow_probe", probe_hit, 0);
      tick();
      do_rel(1);
      for (int i = 0; i < 5; i++) begin
         check("no_aw_before_head", aw_valid, 0);
         tick();
      end
      do_rel(0);
      for (int i = 2; i < DEPTH; i++) do_rel(i);
      wait_empty("out_of_order");

      // W backpressure 1,0,1,0...
      w_toggle = 1'b1;
      do_enq(32'h8000_4000, rand_line());
      do_rel(0);
      wait_empty("backpressure");
      w_toggle = 1'b0;

      // pointer wrap
      do_reset();
      for (int i = 0; i < 6; i++) begin
         check("wrap_idx", enq_idx, i % DEPTH);
         do_enq(32'h8000_5000 + 32'(i * 32), rand_line());
         do_rel(i % DEPTH);
         wait_empty("wrap");
      end

      // randomized traffic
      aw_pct = 60; w_pct = 70; b_pct = 50;
      for (int c = 0; c < 500; c++) begin
         enq_valid     = ($urandom_range(0, 1) == 1);
         enq_addr      = 32'h8000_0000 | (32'($urandom_range(0, 15)) << OFF_W) | 32'($urandom_range(0, 31));
         enq_data      = rand_line();
         release_valid = ($urandom_range(0, 9) < 3);
         release_idx   = IDX_W'($urandom_range(0, DEPTH - 1));
         probe_addr    = 32'h8000_0000 | (32'($urandom_range(0, 15)) << OFF_W);
         tick();
      end
      enq_valid = 1'b0;
      release_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (m_valid[i] && !m_rel[i]) do_rel(i);
      wait_empty("random_drain");

      // reset in the middle of the W burst
      aw_pct = 100; w_pct = 100; b_pct = 100;
      probe_addr = 32'h8000_6000;
      do_enq(32'h8000_6000, rand_line());
      do_rel(m_tail == 0 ? DEPTH - 1 : m_tail - 1);
      n = 0;
      while (!(w_valid && bcount == 2) && n < 50) begin
         tick();
         n++;
      end
      check("reached_beat2", bcount, 2);
      rst = 1'b0;
      #1;
      check("midrst_aw_valid", aw_valid, 0);
      check("midrst_w_valid", w_valid, 0);
      check("midrst_enq_ready", enq_ready, 1);
      check("midrst_probe_hit", probe_hit, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      do_enq(32'h8000_7000, rand_line());
      do_rel(0);
      wait_empty("after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
